// File: rtl/cpu_sequencer.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC over a synchronous
// instruction memory, an 8x32 register file and an external combinational ALU.
module cpu_sequencer #(
    parameter int AW = 8
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start,
    output logic          o_busy,
    output logic          o_halted,
    output logic          o_err,
    output logic [31:0]   o_retired,
    output logic          o_imem_en,
    output logic [AW-1:0] o_imem_addr,
    input  logic [31:0]   i_imem_rdata,
    output logic [3:0]    o_alu_op,
    output logic [31:0]   o_alu_a,
    output logic [31:0]   o_alu_b,
    input  logic [31:0]   i_alu_result,
    input  logic          i_alu_zero,
    input  logic          i_alu_gt,
    input  logic [2:0]    i_dbg_addr,
    output logic [31:0]   o_dbg_data
);

    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_LDI  = 4'd4;
    localparam logic [3:0] OP_BEQ  = 4'd5;
    localparam logic [3:0] OP_BGT  = 4'd6;
    localparam logic [3:0] OP_HALT = 4'd7;
    localparam logic [3:0] OP_NOP  = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_HALT
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [AW-1:0] r_pc;
    logic [31:0]   r_ir;
    logic [31:0]   r_regs [0:7];
    logic          r_halted;
    logic          r_err;
    logic [31:0]   r_retired;

    logic [3:0]    w_opc;
    logic [2:0]    w_rd;
    logic [2:0]    w_rs1;
    logic [2:0]    w_rs2;
    logic [15:0]   w_imm;
    logic [AW-1:0] w_target;
    logic [AW-1:0] w_pc_inc;
    logic [31:0]   w_rs1_val;
    logic [31:0]   w_rs2_val;
    logic          w_is_alu;
    logic          w_is_halt;
    logic          w_illegal;
    logic          w_br_taken;
    logic          w_wr_en;
    logic [31:0]   w_wr_data;
    logic          w_unused;

    assign w_opc    = r_ir[31:28];
    assign w_rd     = r_ir[27:25];
    assign w_rs1    = r_ir[24:22];
    assign w_rs2    = r_ir[21:19];
    assign w_imm    = r_ir[15:0];
    assign w_target = r_ir[AW-1:0];
    assign w_unused = ^r_ir[18:16];
    assign w_pc_inc = r_pc + {{(AW-1){1'b0}}, 1'b1};

    // R0 is hardwired to zero on every read port
    assign w_rs1_val = (w_rs1 == 3'd0) ? 32'd0 : r_regs[w_rs1];
    assign w_rs2_val = (w_rs2 == 3'd0) ? 32'd0 : r_regs[w_rs2];

    assign w_is_alu   = (w_opc[3:2] == 2'b00);
    assign w_is_halt  = (w_opc == OP_HALT);
    assign w_illegal  = w_opc[3] && (w_opc != OP_NOP);
    assign w_br_taken = ((w_opc == OP_BEQ) && i_alu_zero) ||
                        ((w_opc == OP_BGT) && i_alu_gt);
    assign w_wr_en    = (w_is_alu || (w_opc == OP_LDI)) && (w_rd != 3'd0);
    assign w_wr_data  = w_is_alu ? i_alu_result : {16'd0, w_imm};

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_HALT: if (i_start) w_next = S_FETCH;
            S_FETCH:        w_next = S_DECODE;
            S_DECODE:       w_next = S_EXEC;
            S_EXEC:         w_next = (w_is_halt || w_illegal) ? S_HALT : S_FETCH;
            default:        w_next = S_IDLE;
        endcase
    end

    // ALU is held idle (NOP, zero operands) outside EXEC
    always_comb begin
        o_busy    = (r_state == S_FETCH) || (r_state == S_DECODE) || (r_state == S_EXEC);
        o_imem_en = (r_state == S_FETCH);
        o_alu_op  = OP_NOP;
        o_alu_a   = 32'd0;
        o_alu_b   = 32'd0;
        if (r_state == S_EXEC) begin
            if (w_is_alu) begin
                o_alu_op = w_opc;
                o_alu_a  = w_rs1_val;
                o_alu_b  = w_rs2_val;
            end else if ((w_opc == OP_BEQ) || (w_opc == OP_BGT)) begin
                o_alu_op = OP_SUB;
                o_alu_a  = w_rs1_val;
                o_alu_b  = w_rs2_val;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pc      <= '0;
            r_ir      <= '0;
            r_halted  <= 1'b0;
            r_err     <= 1'b0;
            r_retired <= '0;
            for (int i = 0; i < 8; i++) r_regs[i] <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_HALT: begin
                    if (i_start) begin
                        r_pc     <= '0;
                        r_halted <= 1'b0;
                        r_err    <= 1'b0;
                    end
                end
                S_DECODE: r_ir <= i_imem_rdata;
                S_EXEC: begin
                    r_pc <= w_br_taken ? w_target : w_pc_inc;
                    if (w_wr_en) r_regs[w_rd] <= w_wr_data;
                    // illegal opcodes stop the machine without retiring
                    if (!w_illegal) r_retired <= r_retired + 32'd1;
                    if (w_is_halt || w_illegal) r_halted <= 1'b1;
                    if (w_illegal) r_err <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign o_halted    = r_halted;
    assign o_err       = r_err;
    assign o_retired   = r_retired;
    assign o_imem_addr = r_pc;
    assign o_dbg_data  = (i_dbg_addr == 3'd0) ? 32'd0 : r_regs[i_dbg_addr];

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: expected fetch addresses and halt status
// are queued by the stimulus; a monitor pops and compares them as the DUT acts.
module tb_cpu_sequencer;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_start = 1'b0;
    logic        o_busy, o_halted, o_err, o_imem_en;
    logic [31:0] o_retired;
    logic [7:0]  o_imem_addr;
    logic [31:0] i_imem_rdata;
    logic [3:0]  o_alu_op;
    logic [31:0] o_alu_a, o_alu_b, i_alu_result;
    logic        i_alu_zero, i_alu_gt;
    logic [2:0]  i_dbg_addr = 3'd0;
    logic [31:0] o_dbg_data;

    cpu_sequencer #(.AW(8)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start),
        .o_busy(o_busy), .o_halted(o_halted), .o_err(o_err), .o_retired(o_retired),
        .o_imem_en(o_imem_en), .o_imem_addr(o_imem_addr), .i_imem_rdata(i_imem_rdata),
        .o_alu_op(o_alu_op), .o_alu_a(o_alu_a), .o_alu_b(o_alu_b),
        .i_alu_result(i_alu_result), .i_alu_zero(i_alu_zero), .i_alu_gt(i_alu_gt),
        .i_dbg_addr(i_dbg_addr), .o_dbg_data(o_dbg_data)
    );

    always #5 i_clk = ~i_clk;

    // external ALU and instruction memory
    always_comb begin
        i_alu_result = 32'd0;
        case (o_alu_op)
            4'd0: i_alu_result = o_alu_a + o_alu_b;
            4'd1: i_alu_result = o_alu_a - o_alu_b;
            4'd2: i_alu_result = o_alu_a & o_alu_b;
            4'd3: i_alu_result = o_alu_a | o_alu_b;
            default: i_alu_result = 32'd0;
        endcase
        i_alu_zero = (i_alu_result == 32'd0);
        i_alu_gt   = ($signed(o_alu_a) > $signed(o_alu_b));
    end

    logic [31:0] mem [0:255];
    always @(posedge i_clk) if (o_imem_en) i_imem_rdata <= mem[o_imem_addr];

    typedef struct { logic [31:0] retired; logic err; } done_t;
    logic [7:0] exp_fetch[$];
    done_t      exp_done[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] enc(input logic [3:0] op, input logic [2:0] rd,
                                        input logic [2:0] rs1, input logic [2:0] rs2,
                                        input logic [15:0] imm);
        return {op, rd, rs1, rs2, 3'b000, imm};
    endfunction

    // monitor: every fetch and every halt event is matched against the queues
    logic prev_halted = 1'b0;
    always @(negedge i_clk) begin
        if (o_imem_en) begin
            if (exp_fetch.size() == 0) chk("unexpected_fetch", {24'd0, o_imem_addr}, 32'hFFFF_FFFF);
            else chk("fetch_addr", {24'd0, o_imem_addr}, {24'd0, exp_fetch.pop_front()});
        end
        if (o_halted && !prev_halted) begin
            if (exp_done.size() == 0) chk("unexpected_halt", 32'd1, 32'd0);
            else begin
                done_t d;
                d = exp_done.pop_front();
                chk("halt_retired", o_retired, d.retired);
                chk("halt_err", {31'd0, o_err}, {31'd0, d.err});
            end
        end
        prev_halted <= o_halted;
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = enc(4'd7, 3'd0, 3'd0, 3'd0, 16'd0);
    endtask

    task automatic push_fetch(input int n, input logic [7:0] a [16]);
        for (int i = 0; i < n; i++) exp_fetch.push_back(a[i]);
    endtask

    task automatic push_done(input logic [31:0] r, input logic e);
        done_t d;
        d.retired = r;
        d.err = e;
        exp_done.push_back(d);
    endtask

    // start, optionally poke start while busy at loop step poke, run to halt
    task automatic run(input int exp_cycles, input int poke);
        int n;
        n = 0;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        chk("busy_after_start", {31'd0, o_busy}, 32'd1);
        chk("halted_cleared", {31'd0, o_halted}, 32'd0);
        chk("err_cleared", {31'd0, o_err}, 32'd0);
        while (o_busy && n < 300) begin
            if (n == poke) i_start = 1'b1;
            tick();
            i_start = 1'b0;
            n++;
        end
        chk("busy_cycles", n, exp_cycles);
        chk("halted_set", {31'd0, o_halted}, 32'd1);
    endtask

    task automatic chk_reg(input logic [2:0] idx, input logic [31:0] exp);
        i_dbg_addr = idx;
        #1;
        chk($sformatf("reg_R%0d", idx), o_dbg_data, exp);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, {31'd0, o_busy}, 32'd0);
        chk({tag, "_halted"}, {31'd0, o_halted}, 32'd0);
        chk({tag, "_err"}, {31'd0, o_err}, 32'd0);
        chk({tag, "_retired"}, o_retired, 32'd0);
        chk({tag, "_imem_en"}, {31'd0, o_imem_en}, 32'd0);
        chk({tag, "_imem_addr"}, {24'd0, o_imem_addr}, 32'd0);
        chk({tag, "_alu_op"}, {28'd0, o_alu_op}, 32'd15);
        chk({tag, "_alu_a"}, o_alu_a, 32'd0);
        chk({tag, "_alu_b"}, o_alu_b, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] f [16];
        int n;
        clear_mem();
        tick(); tick();
        i_rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i == 0 || i == 9) chk_reset_outputs("idle");
        end

        // LDI/SUB/OR then HALT; a start pulse mid-run must be ignored
        mem[0] = enc(4'd4, 3'd1, 3'd0, 3'd0, 16'd5);
        mem[1] = enc(4'd4, 3'd2, 3'd0, 3'd0, 16'd3);
        mem[2] = enc(4'd1, 3'd3, 3'd1, 3'd2, 16'd0);
        mem[3] = enc(4'd3, 3'd4, 3'd1, 3'd2, 16'd0);
        mem[4] = enc(4'd7, 3'd0, 3'd0, 3'd0, 16'd0);
        f = '{0, 1, 2, 3, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        push_fetch(5, f);
        push_done(32'd5, 1'b0);
        run(15, 4);
        chk_reg(3'd3, 32'd2);
        chk_reg(3'd4, 32'd7);
        chk_reg(3'd1, 32'd5);

        // signed BGT taken, BEQ taken, BEQ not taken
        clear_mem();
        mem[0] = enc(4'd4, 3'd1, 3'd0, 3'd0, 16'hFFFF);
        mem[1] = enc(4'd1, 3'd1, 3'd0, 3'd1, 16'd0);
        mem[2] = enc(4'd6, 3'd0, 3'd0, 3'd1, 16'd5);
        mem[5] = enc(4'd5, 3'd0, 3'd1, 3'd1, 16'd8);
        mem[8] = enc(4'd5, 3'd0, 3'd1, 3'd0, 16'd20);
        f = '{0, 1, 2, 5, 8, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        push_fetch(6, f);
        push_done(32'd11, 1'b0);
        run(18, -1);
        chk_reg(3'd1, 32'hFFFF_0001);

        // write to R0 is discarded
        clear_mem();
        mem[0] = enc(4'd0, 3'd0, 3'd1, 3'd1, 16'd0);
        f = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        push_fetch(2, f);
        push_done(32'd13, 1'b0);
        run(6, -1);
        chk_reg(3'd0, 32'd0);

        // illegal opcode: halts with err, does not retire
        mem[0] = enc(4'd9, 3'd2, 3'd0, 3'd0, 16'd0);
        f = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        push_fetch(1, f);
        push_done(32'd13, 1'b1);
        run(3, -1);
        chk("illegal_err", {31'd0, o_err}, 32'd1);

        // restart from PC 0 clears err
        mem[0] = enc(4'd4, 3'd2, 3'd0, 3'd0, 16'h1234);
        f = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        push_fetch(2, f);
        push_done(32'd15, 1'b0);
        run(6, -1);
        chk_reg(3'd2, 32'h1234);

        // PC wrap 255 -> 0 and retired wrap, from a clean reset
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        force dut.r_retired = 32'hFFFF_FFFF;
        tick();
        release dut.r_retired;
        chk("retired_preset", o_retired, 32'hFFFF_FFFF);
        clear_mem();
        mem[0]   = enc(4'd4, 3'd6, 3'd0, 3'd0, 16'd1);
        mem[1]   = enc(4'd0, 3'd7, 3'd7, 3'd6, 16'd0);
        mem[2]   = enc(4'd4, 3'd5, 3'd0, 3'd0, 16'd2);
        mem[3]   = enc(4'd5, 3'd0, 3'd7, 3'd5, 16'd5);
        mem[4]   = enc(4'd5, 3'd0, 3'd0, 3'd0, 16'd255);
        mem[255] = enc(4'hF, 3'd0, 3'd0, 3'd0, 16'd0);
        f = '{0, 1, 2, 3, 4, 255, 0, 1, 2, 3, 5, 0, 0, 0, 0, 0};
        push_fetch(11, f);
        push_done(32'd10, 1'b0);
        run(33, -1);
        chk_reg(3'd7, 32'd2);

        // rst during EXEC of ADD R5: no write-back, reset values next cycle
        clear_mem();
        mem[0] = enc(4'd4, 3'd1, 3'd0, 3'd0, 16'd7);
        mem[1] = enc(4'd0, 3'd5, 3'd1, 3'd1, 16'd0);
        f = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        push_fetch(2, f);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        n = 0;
        while (o_alu_op != 4'd0 && n < 20) begin
            tick();
            n++;
        end
        chk("add_exec_reached", {31'd0, (n < 20)}, 32'd1);
        chk("add_alu_a", o_alu_a, 32'd7);
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        chk_reset_outputs("rst_exec");
        chk_reg(3'd5, 32'd0);
        chk_reg(3'd1, 32'd0);

        // rst and start together: rst wins
        i_rst = 1'b1;
        i_start = 1'b1;
        tick();
        i_rst = 1'b0;
        i_start = 1'b0;
        chk("rst_start_busy", {31'd0, o_busy}, 32'd0);
        tick();
        chk("rst_start_imem_en", {31'd0, o_imem_en}, 32'd0);

        tick(); tick();
        chk("fetch_queue_empty", exp_fetch.size(), 32'd0);
        chk("done_queue_empty", exp_done.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Multi-cycle instruction sequencer for the SoC CPU. It is the issuing end of the ALU interface. It fetches 32-bit instructions from a synchronous instruction memory and holds an 8 x 32 register file. For each instruction it drives the combinational ALU's op/a/b inputs, then consumes result/zero/gt to write back or branch. It sits between the instruction ROM/RAM and the ALU and exposes start/busy/halt status to the host.

## Interface
- AW, 8: instruction address width; PC and branch targets are AW bits.
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins execution at PC 0 when not busy.
- busy  out  1  high from the cycle after an accepted start until HALT/illegal is executed.
- halted  out  1  sticky; set on HALT or illegal opcode, cleared by start or rst.
- err  out  1  sticky; set on illegal opcode, cleared by start or rst.
- retired  out  32  count of retired instructions, wraps 0xFFFFFFFF -> 0.
- imem_en  out  1  instruction read strobe.
- imem_addr  out  AW  instruction address (= PC).
- imem_rdata  in  32  instruction word, valid the cycle after imem_en.
- alu_op  out  4  ALU opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 15 NOP.
- alu_a, alu_b  out  32  ALU operands.
- alu_result  in  32  ALU result (combinational from alu_op/a/b).
- alu_zero, alu_gt  in  1  ALU flags: result==0, signed a>b.
- dbg_addr  in  3  register index for debug read.
- dbg_data  out  32  combinational read of register dbg_addr.

## Operation
- Instruction word: [31:28] opcode, [27:25] rd, [24:22] rs1, [21:19] rs2, [15:0] imm16, [AW-1:0] branch target.
- Opcodes:
  - 0-3: rd <= alu_result with alu_op = opcode, a = R[rs1], b = R[rs2].
  - 4 LDI: rd <= zero-extended imm16. ALU is not used; alu_op = 15.
  - 5 BEQ: alu_op = SUB; if alu_zero then PC <= target.
  - 6 BGT: alu_op = SUB; if alu_gt then PC <= target.
  - 7 HALT.
  - 15 NOP.
  - 8-14 illegal.
- R0 reads as zero; writes to R0 are discarded.
- The non-taken path, and every other instruction, advances PC <= PC+1 mod 2^AW. Wrap from 2^AW-1 to 0 is legal.
- States:
  - IDLE: start moves to FETCH with PC=0 and clears halted/err.
  - FETCH: assert imem_en with imem_addr = PC.
  - DECODE: latch imem_rdata into IR.
  - EXEC: drive the ALU, sample result and flags, write back, update PC, increment retired. Next state is FETCH, or HALT for HALT/illegal.
  - HALT: set halted (and err if illegal); busy drops. start returns to FETCH at PC=0.
- Retirement: HALT and NOP retire, illegal does not. retired is not cleared by start, only by rst.
- Register file survives start and is cleared only by rst.
- start is ignored in FETCH/DECODE/EXEC.

## Timing
- Reset values: state IDLE, PC 0, IR 0, all registers 0, busy 0, halted 0, err 0, retired 0, imem_en 0, imem_addr 0, alu_op 15, alu_a 0, alu_b 0.
- Outside EXEC the ALU inputs are idle: alu_op=15, a=b=0.
- Start timing: start sampled in cycle T puts FETCH in T+1 and busy high from T+1.
- Instruction timing: each instruction takes exactly 3 cycles (FETCH, DECODE, EXEC). A write in EXEC is visible to the next instruction's EXEC and to dbg_data the following cycle.
- imem_en is high only in FETCH; imem_rdata is used only in DECODE.
- The ALU has zero latency; result and flags are sampled at the end of the same EXEC cycle.
- rst during any state aborts the instruction with no write-back, and all reset values apply the next cycle.
- start and rst in the same cycle: rst wins.

## Test plan
- Reset, then no start for 10 cycles -> busy=0, halted=0, retired=0, imem_en never asserted, alu_op=15.
- Program LDI R1,5; LDI R2,3; SUB R3,R1,R2; OR R4,R1,R2; HALT -> R3=2, R4=7, retired=5, halted=1, busy low 15 cycles after start.
- Signed branch: LDI R1,0xFFFF, SUB R1,R0,R1 (R1 = 0xFFFF0001, negative); BGT R0,R1,target -> taken. Also BEQ R1,R1 -> taken. Also BEQ R1,R0 -> not taken, PC+1.
- Register 0: ADD R0,R1,R1 then dbg_addr=0 -> dbg_data=0. Illegal opcode 9 -> halted=1, err=1, retired unchanged. Then start -> err=0, restart at PC 0.
- PC wrap with AW=8: NOP at 255 and LDI at 0 -> fetch sequence 255 then 0. Also retired preset near wrap (force 0xFFFFFFFF) + 1 -> 0.
- rst asserted during EXEC of ADD R5 -> R5 stays 0, all outputs at reset values next cycle. start issued while busy -> ignored, PC unaffected.
